// File: rtl/dino_game_ctrl.sv
// Dino game sequencer: IDLE / RUNNING / GAME_OVER control, button edge detect,
// BCD score and high score, scroll speed level.
// Ports:
//   clk, rst            - pixel clock, synchronous active-high reset
//   i_btn               - raw asynchronous button level
//   i_game_tick_60hz    - one-clk frame pulse (drives game-over lockout)
//   i_game_tick_20hz    - one-clk pulse every third frame (drives scoring)
//   i_collision         - sticky collision flag from graphics
//   o_state             - 00 IDLE, 01 RUNNING, 10 GAME_OVER
//   o_running           - high in RUNNING
//   o_game_start_pulse  - one-clk pulse on game start (clears collision flag)
//   o_jump_pulse        - one-clk pulse on button edge while RUNNING
//   o_score, o_hiscore  - 4-digit BCD, [15:12] thousands
//   o_new_hiscore       - last game set a record
//   o_speed             - current speed level
module dino_game_ctrl #(
    parameter int unsigned LOCKOUT_FRAMES = 30,
    parameter int unsigned SPEED_STEP     = 100,
    parameter int unsigned MAX_SPEED      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn,
    input  logic        i_game_tick_60hz,
    input  logic        i_game_tick_20hz,
    input  logic        i_collision,
    output logic [1:0]  o_state,
    output logic        o_running,
    output logic        o_game_start_pulse,
    output logic        o_jump_pulse,
    output logic [15:0] o_score,
    output logic [15:0] o_hiscore,
    output logic        o_new_hiscore,
    output logic [2:0]  o_speed
);

    localparam int unsigned LOCK_W  = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SPD_W   = 3;
    localparam int unsigned SCORE_W = 16;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic               sync1, sync2, sync3;
    logic               btn_edge_c;
    logic               start_c;
    logic [LOCK_W-1:0]  lockout, lock_nxt;
    logic [CNT_W-1:0]   speed_cnt, cnt_nxt;
    logic [SCORE_W-1:0] score_nxt, hi_nxt;
    logic [SPD_W-1:0]   speed_nxt;
    logic               new_hi_nxt, start_nxt, jump_nxt;

    // BCD increment with per-digit carry
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign btn_edge_c = sync2 & ~sync3;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            sync1              <= 1'b0;
            sync2              <= 1'b0;
            sync3              <= 1'b0;
            lockout            <= '0;
            speed_cnt          <= '0;
            o_state            <= 2'b00;
            o_running          <= 1'b0;
            o_game_start_pulse <= 1'b0;
            o_jump_pulse       <= 1'b0;
            o_score            <= '0;
            o_hiscore          <= '0;
            o_new_hiscore      <= 1'b0;
            o_speed            <= '0;
        end else begin
            state              <= state_nxt;
            sync1              <= i_btn;
            sync2              <= sync1;
            sync3              <= sync2;
            lockout            <= lock_nxt;
            speed_cnt          <= cnt_nxt;
            o_state            <= state_nxt;
            o_running          <= (state_nxt == ST_RUN);
            o_game_start_pulse <= start_nxt;
            o_jump_pulse       <= jump_nxt;
            o_score            <= score_nxt;
            o_hiscore          <= hi_nxt;
            o_new_hiscore      <= new_hi_nxt;
            o_speed            <= speed_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        lock_nxt   = lockout;
        cnt_nxt    = speed_cnt;
        score_nxt  = o_score;
        hi_nxt     = o_hiscore;
        new_hi_nxt = o_new_hiscore;
        speed_nxt  = o_speed;
        start_nxt  = 1'b0;
        jump_nxt   = 1'b0;
        start_c    = 1'b0;

        case (state)
            ST_IDLE: begin
                start_c = btn_edge_c;
            end
            ST_RUN: begin
                // Collision flag is stale during the start-pulse cycle
                if (i_collision && !o_game_start_pulse) begin
                    state_nxt = ST_OVER;
                    lock_nxt  = LOCK_W'(LOCKOUT_FRAMES);
                    if (o_score > o_hiscore) begin
                        hi_nxt     = o_score;
                        new_hi_nxt = 1'b1;
                    end
                end else if (i_game_tick_20hz) begin
                    if (o_score != SCORE_MAX) begin
                        score_nxt = bcd_inc(o_score);
                    end
                    if (speed_cnt == CNT_W'(SPEED_STEP - 1)) begin
                        cnt_nxt = '0;
                        if (o_speed < SPD_W'(MAX_SPEED)) begin
                            speed_nxt = o_speed + SPD_W'(1);
                        end
                    end else begin
                        cnt_nxt = speed_cnt + CNT_W'(1);
                    end
                end
                jump_nxt = btn_edge_c;
            end
            ST_OVER: begin
                if (i_game_tick_60hz && (lockout != '0)) begin
                    lock_nxt = lockout - LOCK_W'(1);
                end
                // Edge judged against the pre-decrement lockout
                start_c = btn_edge_c && (lockout == '0);
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (start_c) begin
            state_nxt  = ST_RUN;
            start_nxt  = 1'b1;
            score_nxt  = '0;
            speed_nxt  = SPD_W'(1);
            cnt_nxt    = '0;
            new_hi_nxt = 1'b0;
        end
    end

endmodule
